pes_prio_arb: RTL and testbench
===============================

Name: pes_prio_arb

Overview:
- Parametrised, registered successor to the team's 8-input combinational priority encoder.
- Captures request pulses into a sticky pending vector and emits one granted index per cycle over a valid/ready handshake.
- The served request bit is cleared as its index is issued.
- Run-time mode selects fixed priority (highest index wins) or round-robin. Sits between interrupt/event sources and a single-index consumer.

Parameters:
- N, 8, number of request lines; power of two, >= 2.
- W, $clog2(N), index width; derived localparam, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  request capture enable; when 0, i is ignored and pending still drains.
- i  input  N  request lines, sampled every clk edge while en=1.
- mode  input  1  0 = fixed priority, 1 = round-robin.
- clr  input  1  synchronous flush.
- y  output  W  granted index; 0 whenever y_valid=0.
- y_valid  output  1  y holds a grant.
- y_ready  input  1  consumer accepts y this cycle.
- pending  output  N  registered sticky request vector.
- busy  output  1  combinational: |pending | y_valid.
- ovf  output  1  one-cycle pulse: a request arrived on an already-pending line.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: pending=0, y=0, y_valid=0, ovf=0, round-robin pointer ptr=N-1. No tristate outputs; en=0 never floats y.
- Load condition: load = !y_valid | y_ready.
- Selection on load with pending!=0:
  - Grant g is selected from the registered pending only; same-cycle i is not visible.
  - y<=g, y_valid<=1, and pending bit g is cleared at the same edge.
- On load with pending==0: y_valid<=0, y<=0.
- Pending update: pending_next = (pending & ~served_onehot) | (en ? i : 0). A re-request on the line being served in that cycle re-sets its bit, with no ovf.
- Latency: i sampled at edge k gives y_valid at edge k+1 at the earliest, i.e. 2 cycles from i asserted to grant visible.
- Backpressure: while y_valid & !y_ready, y and y_valid hold, no selection occurs, and pending only accumulates.
- Fixed mode: highest set index wins (bit N-1 highest). This matches the legacy encoder's ordering.
- Round-robin mode:
  - Search order is ptr, ptr-1, …, 0, N-1, …, ptr+1 (mod N).
  - After a grant g, ptr<=(g-1) mod N.
  - ptr updates only on RR grants and holds in fixed mode. A mode change applies to the next selection.
- ovf: registered; set for one cycle after any edge where en & i[k] & pending[k] & !served_onehot[k] for any k. The request merges and the count is lost.
- clr (synchronous, highest priority below reset):
  - pending<=0, y_valid<=0, y<=0, ptr<=N-1, ovf<=0.
  - i in the clr cycle is discarded.
  - An un-accepted y is dropped.
- Async reset mid-stream: all state returns immediately to reset values, independent of clk.
- Width rules: all index arithmetic is mod N on W bits; N=2 must work (W=1).

Test Plan (N=8):
1. Reset: assert rst_n=0 mid-cycle with y_valid=1 -> y=0, y_valid=0, pending=0x00, busy=0, ovf=0 immediately, without a clk edge.
2. Fixed priority: mode=0, y_ready=1, en=1, i=0xA4 for one cycle at edge 0 -> y=7 at edge 1, 5 at edge 2, 2 at edge 3; y_valid=0, y=0 at edge 4; pending 0xA4→0x24→0x04→0x00.
3. Backpressure: as scenario 2 with y_ready=0 after edge 1 -> y=7 held 5 cycles, pending=0x24. Pulse i=0x80 meanwhile -> pending=0xA4, ovf=0. Release y_ready -> 7, 5, 2.
4. Round-robin: mode=1, en=1, i=0xFF held, y_ready=1 -> grants 7,6,5,4,3,2,1,0,7 on consecutive edges; ovf high from edge 2 onward. Same stimulus with mode=0 -> y=7 every cycle.
5. Overflow: y_ready=0, i=0x03 at edge 0 -> y=1 at edge 1, pending=0x01. Then i=0x01 at edge 2 -> ovf=1 during the cycle after edge 2 only; pending stays 0x01.
6. en gating and clr: en=0 with i=0xFF -> pending unchanged. With pending=0x30, y_valid=1, assert clr and i=0x01 together -> next edge pending=0, y_valid=0, ptr=7; no grant of index 0 follows.

Source files
------------

// File: rtl/pes_prio_arb.sv
// Registered priority arbiter: captures request pulses into a sticky pending
// vector and issues one granted index per cycle over a valid/ready handshake.
// Fixed-priority (highest index wins) or round-robin selection, chosen at run time.
module pes_prio_arb #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         i,
    input  logic                 mode,
    input  logic                 clr,
    output logic [$clog2(N)-1:0] y,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic [N-1:0]         pending,
    output logic                 busy,
    output logic                 ovf
);

    localparam int unsigned W = $clog2(N);
    localparam logic [W-1:0] PtrInit = W'(N - 1);
    localparam logic [W-1:0] IdxOne  = W'(1);

    logic [N-1:0] r_pending;
    logic [W-1:0] r_y;
    logic         r_y_valid;
    logic         r_ovf;
    logic [W-1:0] r_ptr;

    logic         w_load;
    logic         w_grant;
    logic [W-1:0] w_fix_idx;
    logic [W-1:0] w_rr_idx;
    logic [W-1:0] w_rr_cand;
    logic         w_rr_found;
    logic [W-1:0] w_g;
    logic [N-1:0] w_served;
    logic [N-1:0] w_req;
    logic [N-1:0] w_pending_next;
    logic         w_ovf_next;

    assign w_load  = !r_y_valid || y_ready;
    assign w_grant = w_load && (|r_pending);

    // Fixed priority: scan upward so the highest set index is the last one kept.
    always_comb begin
        w_fix_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (r_pending[k]) begin
                w_fix_idx = W'(k);
            end
        end
    end

    // Round-robin: first set bit in the order ptr, ptr-1, ..., wrapping mod N.
    always_comb begin
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        w_rr_cand  = '0;
        for (int d = 0; d < N; d++) begin
            w_rr_cand = r_ptr - W'(d);
            if (!w_rr_found && r_pending[w_rr_cand]) begin
                w_rr_idx   = w_rr_cand;
                w_rr_found = 1'b1;
            end
        end
    end

    // Served one-hot, pending next-state and overflow detection.
    always_comb begin
        w_g            = mode ? w_rr_idx : w_fix_idx;
        w_served       = w_grant ? (N'(1) << w_g) : '0;
        w_req          = en ? i : '0;
        w_pending_next = (r_pending & ~w_served) | w_req;
        // A re-request on the line being served this cycle is not an overflow.
        w_ovf_next     = |(w_req & r_pending & ~w_served);
    end

    // State registers: reset, synchronous flush, then normal grant/accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_ovf     <= 1'b0;
            r_ptr     <= PtrInit;
        end else if (clr) begin
            r_pending <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_ovf     <= 1'b0;
            r_ptr     <= PtrInit;
        end else begin
            r_pending <= w_pending_next;
            r_ovf     <= w_ovf_next;
            if (w_load) begin
                if (w_grant) begin
                    r_y       <= w_g;
                    r_y_valid <= 1'b1;
                    if (mode) begin
                        r_ptr <= w_g - IdxOne;
                    end
                end else begin
                    r_y       <= '0;
                    r_y_valid <= 1'b0;
                end
            end
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign pending = r_pending;
    assign ovf     = r_ovf;
    assign busy    = (|r_pending) || r_y_valid;

endmodule

// File: tb/tb_pes_prio_arb.sv
// Directed bench for pes_prio_arb (N=8): table-driven selection vectors plus
// hand-written multi-cycle sequences for backpressure, overflow, RR and flush.
module tb_pes_prio_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] i = '0;
    logic       mode = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] y;
    logic       y_valid;
    logic       y_ready = 1'b0;
    logic [7:0] pending;
    logic       busy;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    pes_prio_arb #(.N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .i       (i),
        .mode    (mode),
        .clr     (clr),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .pending (pending),
        .busy    (busy),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [7:0] req;
        logic [7:0] req2;
        logic [2:0] y1;
        logic [7:0] pend1;
        logic [2:0] y2;
        logic       v2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        en      = 1'b0;
        i       = '0;
        mode    = 1'b0;
        clr     = 1'b0;
        y_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // {mode, req, req2, y1, pend1, y2, v2}
        vecs[0] = '{1'b0, 8'h01, 8'h00, 3'd0, 8'h00, 3'd0, 1'b0};
        vecs[1] = '{1'b0, 8'hA4, 8'h00, 3'd7, 8'h24, 3'd5, 1'b1};
        vecs[2] = '{1'b0, 8'h81, 8'h80, 3'd7, 8'h81, 3'd7, 1'b1};
        vecs[3] = '{1'b1, 8'h81, 8'h80, 3'd7, 8'h81, 3'd0, 1'b1};
        vecs[4] = '{1'b1, 8'h11, 8'h10, 3'd4, 8'h11, 3'd0, 1'b1};
        vecs[5] = '{1'b0, 8'h11, 8'h10, 3'd4, 8'h11, 3'd4, 1'b1};
        vecs[6] = '{1'b1, 8'h06, 8'h04, 3'd2, 8'h06, 3'd1, 1'b1};
        vecs[7] = '{1'b0, 8'h06, 8'h04, 3'd2, 8'h06, 3'd2, 1'b1};

        // Async reset mid-cycle with y_valid=1
        do_reset();
        en = 1'b1; i = 8'h01; y_ready = 1'b0;
        step();
        i = '0;
        step();
        check("pre_reset_valid", 32'(y_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_y", 32'(y), 32'd0);
        check("rst_valid", 32'(y_valid), 32'd0);
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        // Table-driven selection vectors
        for (int v = 0; v < 8; v++) begin
            do_reset();
            mode = vecs[v].mode; y_ready = 1'b1; en = 1'b1; i = vecs[v].req;
            step();
            check($sformatf("vec%0d_pend0", v), 32'(pending), 32'(vecs[v].req));
            check($sformatf("vec%0d_lat", v), 32'(y_valid), 32'd0);
            i = vecs[v].req2;
            step();
            check($sformatf("vec%0d_y1", v), 32'(y), 32'(vecs[v].y1));
            check($sformatf("vec%0d_v1", v), 32'(y_valid), 32'd1);
            check($sformatf("vec%0d_pend1", v), 32'(pending), 32'(vecs[v].pend1));
            i = '0;
            step();
            check($sformatf("vec%0d_y2", v), 32'(y), 32'(vecs[v].y2));
            check($sformatf("vec%0d_v2", v), 32'(y_valid), 32'(vecs[v].v2));
        end

        // Fixed priority drain of 0xA4
        do_reset();
        mode = 1'b0; y_ready = 1'b1; en = 1'b1; i = 8'hA4;
        step();
        i = '0;
        step();
        check("fix_y7", 32'(y), 32'd7);
        check("fix_p24", 32'(pending), 32'h24);
        step();
        check("fix_y5", 32'(y), 32'd5);
        check("fix_p04", 32'(pending), 32'h04);
        step();
        check("fix_y2", 32'(y), 32'd2);
        check("fix_p00", 32'(pending), 32'h00);
        step();
        check("fix_v0", 32'(y_valid), 32'd0);
        check("fix_y0", 32'(y), 32'd0);
        check("fix_busy0", 32'(busy), 32'd0);

        // Backpressure
        do_reset();
        mode = 1'b0; y_ready = 1'b1; en = 1'b1; i = 8'hA4;
        step();
        i = '0;
        step();
        y_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp_hold_y%0d", k), 32'(y), 32'd7);
            check($sformatf("bp_hold_p%0d", k), 32'(pending), 32'h24);
        end
        i = 8'h80;
        step();
        i = '0;
        check("bp_merge_p", 32'(pending), 32'hA4);
        check("bp_merge_ovf", 32'(ovf), 32'd0);
        check("bp_merge_y", 32'(y), 32'd7);
        y_ready = 1'b1;
        step();
        check("bp_rel_y7", 32'(y), 32'd7);
        step();
        check("bp_rel_y5", 32'(y), 32'd5);
        step();
        check("bp_rel_y2", 32'(y), 32'd2);
        step();
        check("bp_rel_v0", 32'(y_valid), 32'd0);

        // Round-robin with all lines held, then fixed mode
        do_reset();
        mode = 1'b1; y_ready = 1'b1; en = 1'b1; i = 8'hFF;
        step();
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("rr_y%0d", k), 32'(y), 32'((15 - k) % 8));
            if (k >= 1) check($sformatf("rr_ovf%0d", k), 32'(ovf), 32'd1);
        end
        mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("fixall_y%0d", k), 32'(y), 32'd7);
        end

        // Overflow pulse
        do_reset();
        mode = 1'b0; y_ready = 1'b0; en = 1'b1; i = 8'h03;
        step();
        i = '0;
        step();
        check("ovf_y1", 32'(y), 32'd1);
        check("ovf_p01", 32'(pending), 32'h01);
        check("ovf_pre", 32'(ovf), 32'd0);
        i = 8'h01;
        step();
        i = '0;
        check("ovf_pulse", 32'(ovf), 32'd1);
        check("ovf_pend", 32'(pending), 32'h01);
        step();
        check("ovf_clear", 32'(ovf), 32'd0);
        check("ovf_pend2", 32'(pending), 32'h01);

        // en gating and clr flush (ptr moved away from 7 beforehand)
        do_reset();
        mode = 1'b1; y_ready = 1'b0; en = 1'b1; i = 8'h70;
        step();
        i = '0;
        step();
        check("clr_pre_y", 32'(y), 32'd6);
        check("clr_pre_p", 32'(pending), 32'h30);
        en = 1'b0; i = 8'hFF;
        step();
        check("en0_pend", 32'(pending), 32'h30);
        check("en0_ovf", 32'(ovf), 32'd0);
        en = 1'b1; clr = 1'b1; i = 8'h01;
        step();
        clr = 1'b0; i = '0;
        check("clr_pend", 32'(pending), 32'h00);
        check("clr_valid", 32'(y_valid), 32'd0);
        check("clr_y", 32'(y), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("clr_nogrant%0d", k), 32'(y_valid), 32'd0);
        end
        y_ready = 1'b1; i = 8'h81;
        step();
        i = '0;
        step();
        check("clr_ptr7", 32'(y), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
